// File: rtl/grad_pw_pkg.sv
// Shared constants for the piecewise softplus-gradient pipeline: table
// select encodings, index width, positive-table sizing and reset contents.
package grad_pw_pkg;

    localparam logic SEL_POS = 1'b0;
    localparam logic SEL_NEG = 1'b1;
    localparam int   IDX_W   = 5;

    function automatic int pos_n(input int int_w);
        return 8 + 4 * (int_w - 4);
    endfunction

    function automatic logic [7:0] pos_default(input int i);
        case (i)
            0:       return 8'h35;
            1:       return 8'h35;
            2:       return 8'h31;
            3:       return 8'h2C;
            4:       return 8'h27;
            5:       return 8'h24;
            6:       return 8'h21;
            7:       return 8'h1F;
            8:       return 8'h1C;
            9:       return 8'h19;
            10:      return 8'h17;
            11:      return 8'h15;
            12:      return 8'h13;
            13:      return 8'h12;
            14:      return 8'h10;
            15:      return 8'h0F;
            16:      return 8'h0E;
            17:      return 8'h0C;
            18:      return 8'h0B;
            19:      return 8'h0A;
            20:      return 8'h09;
            21:      return 8'h09;
            22:      return 8'h08;
            23:      return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] neg_default(input int i);
        case (i)
            0:       return 8'h2E;
            1:       return 8'h22;
            2:       return 8'h17;
            3:       return 8'h0E;
            4:       return 8'h09;
            5:       return 8'h05;
            6:       return 8'h03;
            7:       return 8'h02;
            8:       return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/grad_pw_index.sv
// Per-lane operand classifier: maps the integer field of an operand to a
// table select, table index and a force-to-zero flag. Purely combinational.
module grad_pw_index
    import grad_pw_pkg::*;
#(
    parameter int INT_W = 8,
    parameter int NEG_N = 16
) (
    input  logic [INT_W-1:0] int_i,
    output logic             sel_o,
    output logic [IDX_W-1:0] index_o,
    output logic             zero_o
);

    localparam int PW = INT_W - 1;

    logic [PW-1:0]    p_s;
    logic [PW-1:0]    sh_s;
    logic [INT_W-1:0] m_s;
    logic [IDX_W-1:0] pos_idx_s;
    logic [IDX_W-1:0] neg_idx_s;
    int               msb_v;

    assign p_s = int_i[PW-1:0];
    // Magnitude of a negative integer field; -2^(INT_W-1) wraps to its unsigned value.
    assign m_s = ~int_i + {{(INT_W-1){1'b0}}, 1'b1};

    // Log-spaced positive index: octave from the MSB, two mantissa bits below it.
    always_comb begin
        msb_v = 0;
        for (int b = 0; b < PW; b++) begin
            if (p_s[b]) begin
                msb_v = b;
            end else begin
                msb_v = msb_v;
            end
        end
        if (msb_v >= 2) begin
            sh_s = p_s >> (msb_v - 2);
        end else begin
            sh_s = p_s;
        end
        if (p_s < PW'(8)) begin
            pos_idx_s = IDX_W'(p_s);
        end else begin
            pos_idx_s = IDX_W'(8 + 4 * (msb_v - 3) + int'(sh_s[1:0]));
        end
    end

    // Negative side is linear in magnitude, zero beyond the table.
    always_comb begin
        neg_idx_s = IDX_W'(m_s - INT_W'(1));
        if (int_i[INT_W-1]) begin
            zero_o = (m_s > INT_W'(NEG_N));
        end else begin
            zero_o = 1'b0;
        end
    end

    assign sel_o   = int_i[INT_W-1];
    assign index_o = sel_o ? neg_idx_s : pos_idx_s;

endmodule

// File: rtl/grad_softplus_pw_pipe.sv
// Two-stage piecewise-constant softplus-gradient pipeline with writable
// lookup tables shared by all lanes and a global stall.
module grad_softplus_pw_pipe
    import grad_pw_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LANES  = 4,
    parameter int NEG_N  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic                    cfg_we,
    input  logic                    cfg_sel,
    input  logic [4:0]              cfg_addr,
    input  logic [DATA_W-1:0]       cfg_data,
    output logic                    cfg_ready
);

    localparam int INT_W  = DATA_W - FRAC_W;
    localparam int POS_N  = pos_n(INT_W);
    localparam int POS_AW = $clog2(POS_N);
    localparam int NEG_AW = $clog2(NEG_N);

    logic                          rdy_q;
    logic                          en_s, cfg_ready_s, cfg_accept_s, in_ready_s;
    logic                          s1_valid_q, s1_valid_d;
    logic [LANES-1:0]              s1_sel_q, s1_zero_q, lane_sel_s, lane_zero_s;
    logic [LANES-1:0][IDX_W-1:0]   s1_idx_q, lane_idx_s;
    logic                          s2_valid_q;
    logic [LANES*DATA_W-1:0]       s2_data_q, s2_data_d;
    logic [DATA_W-1:0]             pos_q [POS_N];
    logic [DATA_W-1:0]             neg_q [NEG_N];
    logic [LANES*FRAC_W-1:0]       unused_frac_s;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        grad_pw_index #(
            .INT_W (INT_W),
            .NEG_N (NEG_N)
        ) u_index (
            .int_i   (in_data[l*DATA_W+FRAC_W +: INT_W]),
            .sel_o   (lane_sel_s[l]),
            .index_o (lane_idx_s[l]),
            .zero_o  (lane_zero_s[l])
        );
        assign unused_frac_s[l*FRAC_W +: FRAC_W] = in_data[l*DATA_W +: FRAC_W];
    end

    // Handshake: a table write preempts a new vector and needs an empty pipe.
    always_comb begin
        en_s         = !s2_valid_q || out_ready;
        cfg_ready_s  = rdy_q && !s1_valid_q && !s2_valid_q;
        cfg_accept_s = cfg_we && cfg_ready_s;
        in_ready_s   = rdy_q && en_s && !cfg_accept_s;
        s1_valid_d   = in_valid && in_ready_s;
    end

    // Shared table read for every lane.
    always_comb begin
        s2_data_d = '0;
        for (int l = 0; l < LANES; l++) begin
            if (s1_zero_q[l]) begin
                s2_data_d[l*DATA_W +: DATA_W] = '0;
            end else if (s1_sel_q[l] == SEL_NEG) begin
                s2_data_d[l*DATA_W +: DATA_W] = neg_q[s1_idx_q[l][NEG_AW-1:0]];
            end else begin
                s2_data_d[l*DATA_W +: DATA_W] = pos_q[s1_idx_q[l][POS_AW-1:0]];
            end
        end
    end

    // Holds ready outputs low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    // Table storage; out-of-range writes are accepted but dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < POS_N; i++) pos_q[i] <= DATA_W'(pos_default(i));
            for (int i = 0; i < NEG_N; i++) neg_q[i] <= DATA_W'(neg_default(i));
        end else if (cfg_accept_s) begin
            if (cfg_sel == SEL_POS) begin
                if (int'(cfg_addr) < POS_N) pos_q[cfg_addr[POS_AW-1:0]] <= cfg_data;
            end else begin
                if (int'(cfg_addr) < NEG_N) neg_q[cfg_addr[NEG_AW-1:0]] <= cfg_data;
            end
        end
    end

    // Pipeline stages S1 (index) and S2 (read data), frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sel_q   <= '0;
            s1_zero_q  <= '0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else if (en_s) begin
            s1_valid_q <= s1_valid_d;
            s1_sel_q   <= lane_sel_s;
            s1_zero_q  <= lane_zero_s;
            s1_idx_q   <= lane_idx_s;
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s2_data_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign cfg_ready = cfg_ready_s;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

endmodule

// File: tb/tb_grad_softplus_pw_pipe.sv
// Directed, table-driven bench for grad_softplus_pw_pipe with hand-computed
// expectations and sequences for stalls, table writes and mid-flight reset.
module tb_grad_softplus_pw_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        cfg_we;
    logic        cfg_sel;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_ready;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs [5];

    logic [15:0] pos_ref [9]  = '{16'h35, 16'h35, 16'h31, 16'h2C, 16'h27, 16'h24, 16'h21, 16'h1F, 16'h1C};
    logic [15:0] neg_ref [10] = '{16'h2E, 16'h22, 16'h17, 16'h0E, 16'h09, 16'h05, 16'h03, 16'h02, 16'h01, 16'h00};

    always #5 clk = ~clk;

    grad_softplus_pw_pipe #(
        .DATA_W (16),
        .FRAC_W (8),
        .LANES  (4),
        .NEG_N  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Send one vector with out_ready high and check the 2-cycle latency and result.
    task automatic send_vec(input logic [63:0] din, input logic [63:0] exp, input string nm);
        int w;
        w = 0;
        in_valid  = 1'b1;
        in_data   = din;
        out_ready = 1'b1;
        #1;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk({nm, " accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        chk({nm, " latency"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk({nm, " valid"}, 64'(out_valid), 64'd1);
        chk({nm, " data"}, out_data, exp);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] mk_in(input int i);
        logic [15:0] l0, l3;
        l0 = 16'(i) << 8;
        l3 = 16'h0000 - (16'(i + 1) << 8);
        return {l3, 16'h0000, 16'h0000, l0};
    endfunction

    function automatic logic [63:0] mk_exp(input int i);
        return {neg_ref[i], 16'h0035, 16'h0035, pos_ref[(i < 8) ? i : 8]};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, cyc;
        logic prev_stall;
        logic [63:0] held;
        logic [3:0] pat;

        vecs[0] = '{"ex_pos",   64'h7F80_4F00_0A80_0000, 64'h0007_0009_0019_0035};
        vecs[1] = '{"ex_neg",   64'h8000_F600_F700_FF80, 64'h0000_0000_0001_002E};
        vecs[2] = '{"pos_low",  64'h0800_0700_0300_0100, 64'h001C_001F_002C_0035};
        vecs[3] = '{"pos_high", 64'h7FFF_2C00_1000_0F00, 64'h0007_000C_0013_0015};
        vecs[4] = '{"neg_mix",  64'hEF00_FC00_FF01_FE00, 64'h0000_000E_002E_0022};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst cfg_ready", 64'(cfg_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst in_ready", 64'(in_ready), 64'd1);
        chk("post-rst cfg_ready", 64'(cfg_ready), 64'd1);

        for (int v = 0; v < 5; v++) send_vec(vecs[v].din, vecs[v].dout, vecs[v].name);

        // Streaming with out_ready pattern 1,0,0,1.
        pat = 4'b1001;
        sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
        while (got < 10 && cyc < 200) begin
            out_ready = pat[3 - (cyc % 4)];
            in_valid  = (sent < 10);
            in_data   = mk_in((sent < 10) ? sent : 0);
            #1;
            if (prev_stall) begin
                chk("stall valid held", 64'(out_valid), 64'd1);
                chk("stall data held", out_data, held);
            end
            if (out_valid && out_ready) begin
                chk("stream data", out_data, mk_exp(got));
                got++;
            end
            prev_stall = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream sent", 64'(sent), 64'd10);
        chk("stream received", 64'(got), 64'd10);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stream no extra", 64'(out_valid), 64'd0);

        // Busy pipeline blocks a table write.
        in_valid = 1'b1; in_data = {4{16'h0040}}; out_ready = 1'b0;
        #1;
        chk("busy accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd0; cfg_data = 16'h0100;
        #1;
        chk("busy cfg_ready s1", 64'(cfg_ready), 64'd0);
        @(posedge clk); #1;
        chk("busy cfg_ready s2", 64'(cfg_ready), 64'd0);
        @(posedge clk); #1;
        cfg_we = 1'b0; out_ready = 1'b1;
        #1;
        chk("busy out valid", 64'(out_valid), 64'd1);
        chk("busy write dropped", out_data, {4{16'h0035}});
        @(posedge clk); #1;
        chk("empty cfg_ready", 64'(cfg_ready), 64'd1);
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        send_vec({4{16'h0040}}, {4{16'h0100}}, "pos0 rewritten");

        // Simultaneous write and vector: write first, vector next cycle sees it.
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'd0; cfg_data = 16'h0123;
        in_valid = 1'b1; in_data = {4{16'hFF00}}; out_ready = 1'b1;
        #1;
        chk("collide in_ready", 64'(in_ready), 64'd0);
        chk("collide cfg_ready", 64'(cfg_ready), 64'd1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        #1;
        chk("collide next in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("collide valid", 64'(out_valid), 64'd1);
        chk("collide data", out_data, {4{16'h0123}});
        @(posedge clk); #1;

        // Out-of-range negative-table write is accepted and discarded.
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'd16; cfg_data = 16'h0777;
        #1;
        chk("oor cfg_ready", 64'(cfg_ready), 64'd1);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        send_vec({4{16'hFF00}}, {4{16'h0123}}, "oor discarded");

        // Reset with two vectors in flight.
        in_valid = 1'b1; in_data = {4{16'h0000}}; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = {4{16'hFF00}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("inflight valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 64'(out_valid), 64'd0);
        chk("mid-rst out_data", out_data, 64'd0);
        chk("mid-rst in_ready", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("no partial output 1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("no partial output 2", 64'(out_valid), 64'd0);
        send_vec({16'hFF00, 16'h0000, 16'h0000, 16'h0000},
                 {16'h002E, 16'h0035, 16'h0035, 16'h0035}, "tables restored");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
